// File: rtl/parallel_fir_lx.sv
// L-parallel block FIR with double-buffered coefficient bank, two-stage partial-sum pipeline and Q(FRAC) saturation.
// Optional build macro FIR_ROUND_EN: round half up before the FRAC shift (default: truncate).
module parallel_fir_lx #(
    parameter int TAPS       = 100,
    parameter int L          = 3,
    parameter int DATA_WIDTH = 16,
    parameter int COEF_WIDTH = 16,
    parameter int ACC_WIDTH  = 40,
    parameter int GROUPS     = 4,
    parameter int FRAC       = 15
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       in_valid,
    input  logic [L*DATA_WIDTH-1:0]    x_in,
    input  logic                       coef_wr_en,
    input  logic [$clog2(TAPS)-1:0]    coef_addr,
    input  logic [COEF_WIDTH-1:0]      coef_data,
    input  logic                       coef_commit,
    output logic                       coef_pending,
    output logic                       out_valid,
    output logic [L*DATA_WIDTH-1:0]    y_out,
    output logic                       sat_flag,
    input  logic                       sat_clr
);

    localparam int NDL = TAPS + L - 1;
    localparam int GS  = (TAPS + GROUPS - 1) / GROUPS;
    localparam int PW  = DATA_WIDTH + COEF_WIDTH;

    localparam logic signed [ACC_WIDTH-1:0] MAXV =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] MINV =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
`ifdef FIR_ROUND_EN
    localparam logic signed [ACC_WIDTH-1:0] RND = ACC_WIDTH'(1) << (FRAC - 1);
`endif

    typedef enum logic {IDLE, PENDING} cstate_t;

    cstate_t                       cstate_q;
    logic signed [COEF_WIDTH-1:0]  shadow_q [TAPS];
    logic signed [COEF_WIDTH-1:0]  active_q [TAPS];
    logic signed [DATA_WIDTH-1:0]  dl_q     [NDL];
    logic signed [ACC_WIDTH-1:0]   part_q   [L][GROUPS];
    logic signed [ACC_WIDTH-1:0]   part_d   [L][GROUPS];
    logic signed [PW-1:0]          prod;
    logic signed [ACC_WIDTH-1:0]   acc;
    logic signed [ACC_WIDTH-1:0]   scaled;
    logic [L*DATA_WIDTH-1:0]       y_d, y_q;
    logic                          sat_d, sat_q;
    logic                          v1_q, v2_q, out_valid_q;
    logic                          wr_ok;

    assign wr_ok        = coef_wr_en && (int'(coef_addr) < TAPS);
    assign coef_pending = (cstate_q == PENDING);
    assign out_valid    = out_valid_q;
    assign y_out        = y_q;
    assign sat_flag     = sat_q;

    // The copy reads the pre-edge shadow, so a same-edge write lands after it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cstate_q <= IDLE;
            shadow_q <= '{default: '0};
            active_q <= '{default: '0};
        end else begin
            if (coef_commit) active_q <= shadow_q;
            if (wr_ok) shadow_q[coef_addr] <= coef_data;
            case (cstate_q)
                IDLE:    if (wr_ok) cstate_q <= PENDING;
                PENDING: if (coef_commit && !wr_ok) cstate_q <= IDLE;
                default: cstate_q <= IDLE;
            endcase
        end
    end

    // dl_q[0] is the newest sample; lane p's newest sample sits at index L-1-p.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dl_q <= '{default: '0};
        end else if (clear) begin
            dl_q <= '{default: '0};
        end else if (in_valid) begin
            for (int unsigned i = L; i < NDL; i++) dl_q[i] <= dl_q[i-L];
            for (int unsigned p = 0; p < L; p++)
                dl_q[L-1-p] <= x_in[p*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_comb begin
        part_d = '{default: '0};
        prod   = '0;
        for (int unsigned p = 0; p < L; p++) begin
            for (int unsigned k = 0; k < TAPS; k++) begin
                prod = PW'(dl_q[L-1-p+k]) * PW'(active_q[k]);
                part_d[p][k/GS] = part_d[p][k/GS] + {{(ACC_WIDTH-PW){prod[PW-1]}}, prod};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            part_q <= '{default: '0};
        end else if (v1_q) begin
            part_q <= part_d;
        end
    end

    always_comb begin
        y_d    = '0;
        sat_d  = 1'b0;
        acc    = '0;
        scaled = '0;
        for (int unsigned p = 0; p < L; p++) begin
            acc = '0;
            for (int unsigned g = 0; g < GROUPS; g++) acc = acc + part_q[p][g];
`ifdef FIR_ROUND_EN
            acc = acc + RND;
`endif
            scaled = acc >>> FRAC;
            if (scaled > MAXV) begin
                y_d[p*DATA_WIDTH +: DATA_WIDTH] = MAXV[DATA_WIDTH-1:0];
                sat_d = 1'b1;
            end else if (scaled < MINV) begin
                y_d[p*DATA_WIDTH +: DATA_WIDTH] = MINV[DATA_WIDTH-1:0];
                sat_d = 1'b1;
            end else begin
                y_d[p*DATA_WIDTH +: DATA_WIDTH] = scaled[DATA_WIDTH-1:0];
            end
        end
    end

    // A set from a valid saturating output takes priority over sat_clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            out_valid_q <= 1'b0;
            y_q         <= '0;
            sat_q       <= 1'b0;
        end else begin
            v1_q        <= in_valid && !clear;
            v2_q        <= v1_q && !clear;
            out_valid_q <= v2_q && !clear;
            if (v2_q && !clear) y_q <= y_d;
            sat_q <= (v2_q && !clear && sat_d) || (sat_q && !sat_clr);
        end
    end

endmodule

// File: tb/tb_parallel_fir_lx.sv
// Scoreboard bench for parallel_fir_lx: directed blocks push hand-computed results, a monitor pops on out_valid.
module tb_parallel_fir_lx;
    localparam int L    = 3;
    localparam int DW   = 16;
    localparam int TAPS = 100;
    localparam int AWD  = $clog2(TAPS);

`ifdef FIR_ROUND_EN
    localparam logic [15:0] IMP0 = 16'h4000;
    localparam logic [15:0] IMP1 = 16'h2000;
`else
    localparam logic [15:0] IMP0 = 16'h3FFF;
    localparam logic [15:0] IMP1 = 16'h1FFF;
`endif

    logic              clk = 1'b0;
    logic              rst_n, clear, in_valid, coef_wr_en, coef_commit, sat_clr;
    logic [L*DW-1:0]   x_in;
    logic [AWD-1:0]    coef_addr;
    logic [15:0]       coef_data;
    logic              coef_pending, out_valid, sat_flag;
    logic [L*DW-1:0]   y_out;

    int          checks   = 0;
    int          failures = 0;
    int unsigned cyc      = 0;

    typedef struct {
        int unsigned     cyc;
        logic [L*DW-1:0] y;
        string           name;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    parallel_fir_lx #(
        .TAPS(TAPS), .L(L), .DATA_WIDTH(DW), .COEF_WIDTH(16),
        .ACC_WIDTH(40), .GROUPS(4), .FRAC(15)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .x_in(x_in),
        .coef_wr_en(coef_wr_en), .coef_addr(coef_addr), .coef_data(coef_data),
        .coef_commit(coef_commit), .coef_pending(coef_pending), .out_valid(out_valid),
        .y_out(y_out), .sat_flag(sat_flag), .sat_clr(sat_clr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out_valid actual=%h expected=none", y_out);
            end else begin
                mon_e = sb.pop_front();
                check({mon_e.name, "_data"}, 64'(y_out), 64'(mon_e.y));
                check({mon_e.name, "_latency"}, 64'(cyc), 64'(mon_e.cyc));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input logic [15:0] x0, x1, x2, input bit push, input string name,
                        input logic [15:0] e0, e1, e2);
        in_valid = 1'b1;
        x_in     = {x2, x1, x0};
        tick();
        in_valid = 1'b0;
        if (push) sb.push_back('{cyc + 2, {e2, e1, e0}, name});
    endtask

    task automatic wr(input logic [AWD-1:0] a, input logic [15:0] d);
        coef_wr_en = 1'b1;
        coef_addr  = a;
        coef_data  = d;
        tick();
        coef_wr_en = 1'b0;
    endtask

    task automatic commit();
        coef_commit = 1'b1;
        tick();
        coef_commit = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; coef_wr_en = 1'b0;
        coef_commit = 1'b0; sat_clr = 1'b0; x_in = '0; coef_addr = '0; coef_data = '0;
        #2;
        check("rst_y", 64'(y_out), 64'd0);
        check("rst_ov", 64'(out_valid), 64'd0);
        check("rst_sat", 64'(sat_flag), 64'd0);
        check("rst_pend", 64'(coef_pending), 64'd0);
        idle(2);
        rst_n = 1'b1;
        tick();

        send(16'h0, 16'h0, 16'h0, 1, "zero0", 16'h0, 16'h0, 16'h0);
        send(16'h0, 16'h0, 16'h0, 1, "zero1", 16'h0, 16'h0, 16'h0);

        wr(AWD'(120), 16'h1234);
        check("oob_wr_pend", 64'(coef_pending), 64'd0);
        wr(AWD'(0), 16'h4000);
        check("wr_pend", 64'(coef_pending), 64'd1);
        wr(AWD'(1), 16'h2000);
        commit();
        check("commit_pend", 64'(coef_pending), 64'd0);

        send(16'h7FFF, 16'h0, 16'h0, 1, "imp", IMP0, IMP1, 16'h0);
        send(16'h0, 16'h0, 16'h0, 1, "imp_tail", 16'h0, 16'h0, 16'h0);
        idle(4);

        for (int i = 0; i < 10; i++) begin
            if (i == 5) idle(2);
            if (i == 0) send(16'h400, 16'h400, 16'h400, 1, "strm", 16'h200, 16'h300, 16'h300);
            else        send(16'h400, 16'h400, 16'h400, 1, "strm", 16'h300, 16'h300, 16'h300);
        end

        send(16'h400, 16'h400, 16'h400, 1, "swapA0", 16'h300, 16'h300, 16'h300);
        coef_wr_en = 1'b1; coef_addr = AWD'(0); coef_data = 16'h2000;
        send(16'h400, 16'h400, 16'h400, 1, "swapA1", 16'h300, 16'h300, 16'h300);
        check("swap_pend", 64'(coef_pending), 64'd1);
        coef_addr = AWD'(1); coef_data = 16'h0000;
        send(16'h400, 16'h400, 16'h400, 1, "swapA2", 16'h300, 16'h300, 16'h300);
        coef_wr_en = 1'b0; coef_commit = 1'b1;
        send(16'h400, 16'h400, 16'h400, 1, "swapB3", 16'h100, 16'h100, 16'h100);
        coef_commit = 1'b0;
        check("swap_commit_pend", 64'(coef_pending), 64'd0);
        send(16'h400, 16'h400, 16'h400, 1, "swapB4", 16'h100, 16'h100, 16'h100);

        coef_wr_en = 1'b1; coef_addr = AWD'(1); coef_data = 16'h2000; coef_commit = 1'b1;
        tick();
        coef_wr_en = 1'b0; coef_commit = 1'b0;
        check("wr_commit_pend", 64'(coef_pending), 64'd1);
        send(16'h400, 16'h400, 16'h400, 1, "wc_old", 16'h100, 16'h100, 16'h100);
        commit();
        check("wc_commit_pend", 64'(coef_pending), 64'd0);
        send(16'h400, 16'h400, 16'h400, 1, "wc_new", 16'h200, 16'h200, 16'h200);
        idle(4);

        for (int k = 0; k < TAPS; k++) wr(AWD'(k), 16'h7FFF);
        commit();
        send(16'h7FFF, 16'h7FFF, 16'h7FFF, 1, "satp0", 16'h7FFF, 16'h7FFF, 16'h7FFF);
        send(16'h7FFF, 16'h7FFF, 16'h7FFF, 1, "satp1", 16'h7FFF, 16'h7FFF, 16'h7FFF);
        idle(4);
        check("satp_flag", 64'(sat_flag), 64'd1);
        sat_clr = 1'b1;
        tick();
        sat_clr = 1'b0;
        check("sat_clr_flag", 64'(sat_flag), 64'd0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        send(16'h8000, 16'h8000, 16'h8000, 1, "satn0", 16'h8001, 16'h8000, 16'h8000);
        send(16'h8000, 16'h8000, 16'h8000, 1, "satn1", 16'h8000, 16'h8000, 16'h8000);
        idle(4);
        check("satn_flag", 64'(sat_flag), 64'd1);

        for (int k = 0; k < TAPS; k++)
            wr(AWD'(k), (k == 0) ? 16'h4000 : (k == 1) ? 16'h2000 : 16'h0000);
        commit();
        send(16'h1234, 16'h1234, 16'h1234, 0, "", 16'h0, 16'h0, 16'h0);
        send(16'h1234, 16'h1234, 16'h1234, 0, "", 16'h0, 16'h0, 16'h0);
        clear = 1'b1; in_valid = 1'b1; x_in = {3{16'h7FFF}};
        tick();
        clear = 1'b0; in_valid = 1'b0;
        check("clear_ov", 64'(out_valid), 64'd0);
        send(16'h7FFF, 16'h0, 16'h0, 1, "clr_imp", IMP0, IMP1, 16'h0);
        send(16'h0, 16'h0, 16'h0, 1, "clr_tail", 16'h0, 16'h0, 16'h0);
        idle(4);

        send(16'h7FFF, 16'h0, 16'h0, 0, "", 16'h0, 16'h0, 16'h0);
        send(16'h7FFF, 16'h0, 16'h0, 0, "", 16'h0, 16'h0, 16'h0);
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("midrst_y", 64'(y_out), 64'd0);
        check("midrst_ov", 64'(out_valid), 64'd0);
        check("midrst_sat", 64'(sat_flag), 64'd0);
        check("midrst_pend", 64'(coef_pending), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        send(16'h7FFF, 16'h7FFF, 16'h7FFF, 1, "post_rst", 16'h0, 16'h0, 16'h0);
        send(16'h0, 16'h0, 16'h0, 1, "post_rst_tail", 16'h0, 16'h0, 16'h0);
        idle(4);

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
